// File: rtl/mem_copy_engine_pkg.sv
// Memory-bus definitions shared by the data memory, the pipeline memory stage and
// the copy engine.
package mem_copy_engine_pkg;

  localparam int unsigned BYTE_SIZE  = 4;
  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned MEM_BYTES  = 56;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StFin
  } state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Block-copy bus initiator for the single-port data memory. Copies len words from
// src to dst one word at a time (read cycle, then write cycle), choosing the copy
// direction so that overlapping ranges behave like memmove.
module mem_copy_engine #(
  parameter int unsigned BYTE_SIZE  = mem_copy_engine_pkg::BYTE_SIZE,
  parameter int unsigned ADDR_WIDTH = mem_copy_engine_pkg::ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned MEM_BYTES  = mem_copy_engine_pkg::MEM_BYTES
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [ADDR_WIDTH-1:0]    src_addr_i,
  input  logic [ADDR_WIDTH-1:0]    dst_addr_i,
  input  logic [LEN_WIDTH-1:0]     len_words_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [ADDR_WIDTH-1:0]    mem_addr_o,
  output logic                     mem_we_o,
  output logic [8*BYTE_SIZE-1:0]   mem_wd_o,
  input  logic [8*BYTE_SIZE-1:0]   mem_rd_i
);

  import mem_copy_engine_pkg::*;

  // Wide enough that src + len*BYTE_SIZE can never wrap.
  localparam int unsigned EW = ADDR_WIDTH + LEN_WIDTH + 2;
  localparam int unsigned DW = 8 * BYTE_SIZE;
  localparam logic [ADDR_WIDTH-1:0] Step = ADDR_WIDTH'(BYTE_SIZE);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   src_q, src_d;
  logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]           buf_q, buf_d;
  logic                    err_q, err_d;
  logic                    bwd_q, bwd_d;

  logic [EW-1:0]           span, src_w, dst_w, end_src, end_dst, last_off;
  logic                    range_bad, backward;
  logic [ADDR_WIDTH-1:0]   first_src, first_dst;

  // Range and overlap check on the raw request inputs.
  always_comb begin
    span      = EW'(len_words_i) * EW'(BYTE_SIZE);
    src_w     = EW'(src_addr_i);
    dst_w     = EW'(dst_addr_i);
    end_src   = src_w + span;
    end_dst   = dst_w + span;
    range_bad = (end_src > EW'(MEM_BYTES)) || (end_dst > EW'(MEM_BYTES));
    // Destination starts inside the source block: walk from the top down.
    backward  = (dst_w > src_w) && (dst_w < end_src);
    last_off  = span - EW'(BYTE_SIZE);
    first_src = backward ? ADDR_WIDTH'(src_w + last_off) : src_addr_i;
    first_dst = backward ? ADDR_WIDTH'(dst_w + last_off) : dst_addr_i;
  end

  // Next-state logic: request acceptance, word read, word write, completion.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = err_q;
    bwd_d   = bwd_q;
    unique case (state_q)
      StIdle: begin
        err_d = 1'b0;
        if (start_i) begin
          cnt_d = len_words_i;
          if (len_words_i == '0) begin
            state_d = StFin;
          end else if (range_bad) begin
            err_d   = 1'b1;
            state_d = StFin;
          end else begin
            bwd_d   = backward;
            src_d   = first_src;
            dst_d   = first_dst;
            state_d = StRead;
          end
        end
      end
      StRead: begin
        buf_d   = mem_rd_i;
        state_d = StWrite;
      end
      StWrite: begin
        cnt_d = cnt_q - LEN_WIDTH'(1);
        if (cnt_q == LEN_WIDTH'(1)) begin
          state_d = StFin;
        end else begin
          // Pointers only move when another word follows, so they never leave memory.
          src_d   = bwd_q ? src_q - Step : src_q + Step;
          dst_d   = bwd_q ? dst_q - Step : dst_q + Step;
          state_d = StRead;
        end
      end
      StFin: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
      bwd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      bwd_q   <= bwd_d;
    end
  end

  // Bus and status outputs decoded from registered state only.
  always_comb begin
    busy_o     = 1'b0;
    done_o     = 1'b0;
    mem_addr_o = '0;
    mem_we_o   = 1'b0;
    mem_wd_o   = '0;
    unique case (state_q)
      StRead: begin
        busy_o     = 1'b1;
        mem_addr_o = src_q;
      end
      StWrite: begin
        busy_o     = 1'b1;
        mem_addr_o = dst_q;
        mem_we_o   = 1'b1;
        mem_wd_o   = buf_q;
      end
      StFin:   done_o = 1'b1;
      default: ;
    endcase
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: byte memory responder, memmove-level
// reference model, per-cycle output comparison, directed and random transfers.
module tb_mem_copy_engine;

  localparam int BS = 4;
  localparam int AW = 12;
  localparam int LW = 8;
  localparam int MB = 56;
  localparam int DW = 8 * BS;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            start_i;
  logic [AW-1:0]   src_addr_i, dst_addr_i;
  logic [LW-1:0]   len_words_i;
  logic            busy, done, err, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wd, mem_rd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  mem_copy_engine #(
    .BYTE_SIZE (BS),
    .ADDR_WIDTH(AW),
    .LEN_WIDTH (LW),
    .MEM_BYTES (MB)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .len_words_i(len_words_i),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .mem_addr_o (mem_addr),
    .mem_we_o   (mem_we),
    .mem_wd_o   (mem_wd),
    .mem_rd_i   (mem_rd)
  );

  // Memory, its expected image, and the image loaded on request.
  logic [7:0] mem     [MB];
  logic [7:0] exp_mem [MB];
  logic [7:0] img     [MB];
  logic       load_img = 1'b0;

  // Reference model state for the transfer currently in flight.
  bit          m_active = 1'b0;
  bit          m_legal, m_err, m_bwd;
  int          m_t = 0, m_done_t = 0, m_len = 0, m_src = 0, m_dst = 0;
  logic [31:0] m_snap [256];
  logic        eb, ed, ew;

  task automatic chk(input string name, input longint unsigned act,
                     input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input int a);
    logic [31:0] w = '0;
    for (int b = 0; b < BS; b++) if (a + b < MB) w[8*b +: 8] = mem[a + b];
    return w;
  endfunction

  function automatic int raddr(input int k);
    return m_bwd ? m_src + BS * (m_len - 1 - k) : m_src + BS * k;
  endfunction

  function automatic int waddr(input int k);
    return m_bwd ? m_dst + BS * (m_len - 1 - k) : m_dst + BS * k;
  endfunction

  // Combinational little-endian read; absent bytes read as zero.
  always_comb begin
    mem_rd = '0;
    for (int b = 0; b < BS; b++)
      if (int'(mem_addr) + b < MB) mem_rd[8*b +: 8] = mem[int'(mem_addr) + b];
  end

  // Memory write port plus the timed reference model (memmove of a snapshot).
  always @(posedge clk_i) begin
    if (load_img) begin
      for (int b = 0; b < MB; b++) begin
        mem[b]     = img[b];
        exp_mem[b] = img[b];
      end
    end else begin
      if (mem_we) begin
        for (int b = 0; b < BS; b++) begin
          if (int'(mem_addr) + b < MB) mem[int'(mem_addr) + b] = mem_wd[8*b +: 8];
          else begin
            n_checks++;
            n_errors++;
            $display("FAIL write_out_of_range: got addr %0d", mem_addr);
          end
        end
      end
      if (reset_i) begin
        m_active = 1'b0;
      end else if (m_active) begin
        if (m_legal && (m_t % 2 == 0) && m_t >= 2 && m_t <= 2 * m_len) begin
          for (int b = 0; b < BS; b++)
            exp_mem[waddr(m_t / 2 - 1) + b] = m_snap[m_t / 2 - 1][8*b +: 8];
        end
        if (m_t == m_done_t) m_active = 1'b0;
        else m_t++;
      end else if (start_i) begin
        m_src   = int'(src_addr_i);
        m_dst   = int'(dst_addr_i);
        m_len   = int'(len_words_i);
        m_err   = (m_len != 0) && ((m_src + BS * m_len > MB) || (m_dst + BS * m_len > MB));
        m_legal = (m_len != 0) && !m_err;
        m_bwd   = (m_dst > m_src) && (m_dst < m_src + BS * m_len);
        m_done_t = m_legal ? 2 * m_len + 1 : 1;
        m_t      = 1;
        m_active = 1'b1;
        if (m_legal) for (int k = 0; k < m_len; k++) m_snap[k] = rd_word(raddr(k));
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk_i) begin
    eb = m_active && m_legal && m_t >= 1 && m_t <= 2 * m_len;
    ed = m_active && (m_t == m_done_t);
    ew = eb && (m_t % 2 == 0);
    chk("busy", busy, eb);
    chk("done", done, ed);
    chk("err", err, ed && m_err);
    chk("mem_we", mem_we, ew);
    if (eb && !ew) chk("rd_addr", mem_addr, raddr((m_t - 1) / 2));
    if (ew) begin
      chk("wr_addr", mem_addr, waddr(m_t / 2 - 1));
      chk("wr_data", mem_wd, m_snap[m_t / 2 - 1]);
    end
  end

  task automatic set_img_word(input int a, input logic [31:0] w);
    for (int b = 0; b < BS; b++) img[a + b] = w[8*b +: 8];
  endtask

  task automatic load_image();
    @(negedge clk_i);
    load_img = 1'b1;
    @(negedge clk_i);
    load_img = 1'b0;
  endtask

  task automatic check_image(input string name);
    int nbad = 0;
    for (int b = 0; b < MB; b++) if (mem[b] !== exp_mem[b]) nbad++;
    chk(name, nbad, 0);
  endtask

  // Issue one request and observe a fixed window; optionally pulse start again.
  task automatic run_copy(input int s, input int d, input int l, input int restart_at,
                          output int busy_n, output int done_at, output int done_n,
                          output int err_at_done, output int we_n,
                          output int first_addr, output int first_waddr);
    @(negedge clk_i);
    src_addr_i  = AW'(s);
    dst_addr_i  = AW'(d);
    len_words_i = LW'(l);
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    busy_n = 0; done_at = -1; done_n = 0; err_at_done = -1; we_n = 0;
    first_addr = -1; first_waddr = -1;
    for (int c = 1; c <= 2 * l + 6; c++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) begin
          done_at     = c;
          err_at_done = int'(err);
        end
      end
      if (mem_we) begin
        we_n++;
        if (first_waddr < 0) first_waddr = int'(mem_addr);
      end
      if (c == 1) first_addr = int'(mem_addr);
      if (c == restart_at) begin
        src_addr_i  = AW'(40);
        dst_addr_i  = AW'(44);
        len_words_i = LW'(2);
        start_i     = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bn, da, dn, ea, wn, fa, fw, nd, s, d, l;
    reset_i = 1'b1;
    start_i = 1'b0;
    src_addr_i = '0;
    dst_addr_i = '0;
    len_words_i = '0;
    for (int b = 0; b < MB; b++) img[b] = 8'h00;
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_we", mem_we, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wd", mem_wd, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;

    // Forward copy of four words.
    set_img_word(0, 32'hA3A2A1A0);
    set_img_word(4, 32'hB3B2B1B0);
    set_img_word(8, 32'hC3C2C1C0);
    set_img_word(12, 32'hD3D2D1D0);
    load_image();
    run_copy(0, 32, 4, 0, bn, da, dn, ea, wn, fa, fw);
    chk("fwd_busy_cycles", bn, 8);
    chk("fwd_done_cycle", da, 9);
    chk("fwd_err", ea, 0);
    chk("fwd_word32", rd_word(32), 32'hA3A2A1A0);
    chk("fwd_word44", rd_word(44), 32'hD3D2D1D0);
    chk("fwd_word0", rd_word(0), 32'hA3A2A1A0);
    chk("fwd_word16", rd_word(16), 32'h0);
    check_image("fwd_image");

    // Overlapping copy that must run backward.
    for (int b = 0; b < MB; b++) img[b] = 8'h00;
    set_img_word(0, 32'h11111111);
    set_img_word(4, 32'h22222222);
    set_img_word(8, 32'h33333333);
    load_image();
    run_copy(0, 4, 3, 0, bn, da, dn, ea, wn, fa, fw);
    chk("bwd_first_addr", fa, 8);
    chk("bwd_first_waddr", fw, 12);
    chk("bwd_word4", rd_word(4), 32'h11111111);
    chk("bwd_word8", rd_word(8), 32'h22222222);
    chk("bwd_word12", rd_word(12), 32'h33333333);
    check_image("bwd_image");

    // Range error: source block runs past the end of memory.
    run_copy(48, 0, 3, 0, bn, da, dn, ea, wn, fa, fw);
    chk("rng_done_cycle", da, 1);
    chk("rng_err", ea, 1);
    chk("rng_we_cycles", wn, 0);
    chk("rng_word0", rd_word(0), 32'h11111111);
    check_image("rng_image");

    // Zero-length request.
    run_copy(8, 20, 0, 0, bn, da, dn, ea, wn, fa, fw);
    chk("zero_done_cycle", da, 1);
    chk("zero_err", ea, 0);
    chk("zero_busy_cycles", bn, 0);

    // Start pulsed again mid-transfer is ignored.
    for (int b = 0; b < MB; b++) img[b] = 8'(b + 1);
    load_image();
    run_copy(0, 16, 4, 3, bn, da, dn, ea, wn, fa, fw);
    chk("ign_done_count", dn, 1);
    chk("ign_done_cycle", da, 9);
    chk("ign_word16", rd_word(16), 32'h04030201);
    chk("ign_word28", rd_word(28), 32'h100F0E0D);
    chk("ign_word44", rd_word(44), 32'h302F2E2D);
    check_image("ign_image");

    // Reset during the third write of a four-word copy.
    for (int b = 0; b < MB; b++) img[b] = 8'h00;
    set_img_word(0, 32'h01010101);
    set_img_word(4, 32'h02020202);
    set_img_word(8, 32'h03030303);
    set_img_word(12, 32'h04040404);
    load_image();
    @(negedge clk_i);
    src_addr_i  = AW'(0);
    dst_addr_i  = AW'(32);
    len_words_i = LW'(4);
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    chk("rst_pre_we", mem_we, 1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("rst_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk_i);
    #2;
    reset_i = 1'b0;
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (done) nd++;
    end
    chk("rst_no_done", nd, 0);
    chk("rst_word32", rd_word(32), 32'h01010101);
    chk("rst_word36", rd_word(36), 32'h02020202);
    chk("rst_word40", rd_word(40), 32'h0);
    chk("rst_word44", rd_word(44), 32'h0);
    check_image("rst_image");
    run_copy(0, 32, 4, 0, bn, da, dn, ea, wn, fa, fw);
    chk("rst_again_done", da, 9);
    chk("rst_again_word44", rd_word(44), 32'h04040404);

    // Randomized transfers, mostly word-aligned and in range.
    for (int it = 0; it < 60; it++) begin
      if (it % 6 == 0) begin
        for (int b = 0; b < MB; b++) img[b] = 8'($urandom);
        load_image();
      end
      l = $urandom_range(0, 6);
      if ($urandom_range(0, 3) != 0) begin
        s = 4 * $urandom_range(0, 13);
        d = 4 * $urandom_range(0, 13);
      end else begin
        s = $urandom_range(0, 60);
        d = $urandom_range(0, 60);
      end
      run_copy(s, d, l, 0, bn, da, dn, ea, wn, fa, fw);
      chk("rand_done_count", dn, 1);
      check_image("rand_image");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Bus initiator that drives the single-port byte-addressable data memory's clk/WE/WD/ADDR/RD interface. Memory is little-endian, with combinational read and posedge write.
- Copies a block of N words from a source byte address to a destination byte address, memmove-safe.
- Sits beside the pipeline's memory stage. Shares the memory port through an external mux selected by busy.
- Used for bulk initialisation and test preloading without CPU involvement.

Parameters:
- BYTE_SIZE, 4, bytes per word; matches the memory data width.
- ADDR_WIDTH, 12, byte-address width.
- LEN_WIDTH, 8, width of the word-count input.
- MEM_BYTES, 56, number of physically present memory bytes; sets the legal address limit.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- src_addr  in  ADDR_WIDTH  source byte address, latched on accepted start.
- dst_addr  in  ADDR_WIDTH  destination byte address, latched on accepted start.
- len_words  in  LEN_WIDTH  number of words to copy, latched on accepted start.
- busy  out  1  high in READ and WRITE states.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 means the range check failed and nothing was written.
- mem_addr  out  ADDR_WIDTH  memory ADDR.
- mem_we  out  1  memory WE.
- mem_wd  out  8*BYTE_SIZE  memory WD.
- mem_rd  in  8*BYTE_SIZE  memory RD (combinational from mem_addr).

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - busy=0, done=0, err=0, mem_we=0, mem_addr=0, mem_wd=0.
  - Internal src/dst/count/buffer registers are cleared.
- Reset mid-transfer: mem_we drops immediately and no further writes occur. Words already written stay written. No done pulse is issued.
- FSM states: IDLE, READ, WRITE, FIN.
- IDLE:
  - On start=1, latch the inputs and compute end_src = src + len*BYTE_SIZE and end_dst = dst + len*BYTE_SIZE.
  - Compute both ends at width ADDR_WIDTH+LEN_WIDTH+2 so they never wrap.
  - If len=0 → FIN with err=0.
  - If end_src>MEM_BYTES or end_dst>MEM_BYTES → FIN with err=1.
  - Otherwise → READ.
- Direction:
  - If dst>src and dst<end_src (overlapping forward), copy backward.
  - Backward copy: the first word is at base+(len-1)*BYTE_SIZE and pointers step down by BYTE_SIZE.
  - Otherwise copy forward: the first word is at base and pointers step up by BYTE_SIZE.
  - src==dst is a legal forward copy; it rewrites identical data.
- READ:
  - mem_addr=src_ptr, mem_we=0.
  - At posedge, buffer<=mem_rd, then → WRITE.
- WRITE:
  - mem_addr=dst_ptr, mem_wd=buffer, mem_we=1; the memory commits at this posedge.
  - Both pointers step and count decrements.
  - If count was 1 → FIN, else → READ.
- FIN:
  - done=1 for exactly one cycle; err is held from the IDLE check.
  - Then → IDLE, where err clears to 0.
- Timing:
  - A legal N-word copy keeps busy high for 2N cycles.
  - done asserts in cycle 2N+1 after the start edge.
  - An error or len=0 gives done in the cycle right after the start edge.
- start while not in IDLE (busy or FIN) is ignored; there is no queueing.
- mem_addr, mem_we and mem_wd are decoded from state registers only, with no combinational path from inputs.
- mem_we is 0 outside WRITE.
- Pointers never exceed MEM_BYTES-BYTE_SIZE, guaranteed by the range check. No address wrap-around occurs.

Decomposition:
- Shared package (memory-bus definitions, reused by the memory and the pipeline mem stage):
  - Constants BYTE_SIZE, ADDR_WIDTH, MEM_BYTES.
  - The state encoding IDLE/READ/WRITE/FIN.
- No sub-module needed. The range/overlap check is a combinational block inside the top.
- The bench instantiates the existing memory model as the responder.

Test Plan:
- Forward copy: mem[0..15] preloaded; src=0, dst=32, len=4.
  - Required: busy high 8 cycles; done at cycle 9, err=0.
  - Required: mem[32..47] equals mem[0..15]; mem[0..31] unchanged.
- Overlapping backward copy: words at 0,4,8 = 11111111, 22222222, 33333333; src=0, dst=4, len=3.
  - Required: first mem_addr is 8, first write address is 12.
  - Required: final words at 4,8,12 = 11111111, 22222222, 33333333.
- Range error: src=48, dst=0, len=3 (end_src=60>56).
  - Required: done next cycle with err=1; mem_we never asserted; memory unchanged.
- Zero length: len=0.
  - Required: done next cycle, err=0, busy never high.
- Start ignored: start pulsed again mid-transfer with different src/dst.
  - Required: the original transfer completes unaffected; exactly one done pulse.
- Reset mid-transfer: reset asserted during the third WRITE of a 4-word copy.
  - Required: same-cycle mem_we=0 and busy=0; no done pulse.
  - Required: first two destination words updated, last two untouched; a subsequent start works normally.
